fsm_arb: RTL and testbench
==========================

# fsm_arb

Round-robin scheduler that shares a single nibble-extract work engine among `NUM_REQ` requesters. Each transaction runs through a fixed IDLE → WORK → DONE sequence.
- IDLE: one requester is granted and its byte is captured.
- WORK: the upper nibble of the captured byte is presented on a valid/ready result port, tagged with the requester ID.
- DONE: a single housekeeping cycle advances the arbitration pointer and the completion counter.

The block sits between the requester-side channels and the downstream result consumer.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `DATA_W`, default 8: request data width, at least 4.
- `ID_W`, default `max(1, $clog2(NUM_REQ))`: width of the requester ID.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_data`  in  NUM_REQ*DATA_W  request payloads; requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accepted by the consumer.
- `out_nib`  out  4  captured `data[DATA_W-1 -: 4]`; bit 3 is the MSB.
- `out_id`  out  ID_W  index of the granted requester.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done_count`  out  16  number of completed transactions.

## Operation
State is a registered enum `{IDLE, WORK, DONE}`.

**IDLE**
- The pick logic scans `req_valid` starting at `rr_ptr` and wrapping modulo `NUM_REQ`. The first set bit wins.
- If a winner exists, `req_ready[winner]` is asserted combinationally in the same cycle. On the clock edge the block captures `req_data[winner]` and `winner`, then moves to WORK.
- If there is no winner, `req_ready` is 0 and the block stays in IDLE.

**WORK**
- `out_valid` = 1. `out_nib` and `out_id` come from the capture registers.
- If `out_valid && out_ready` → DONE. Otherwise the block stays in WORK with `out_nib` and `out_id` stable.

**DONE**
- `out_valid` = 0.
- `rr_ptr` ← (captured id + 1) mod `NUM_REQ`.
- `done_count` ← `done_count` + 1, wrapping 0xFFFF → 0x0000.
- Next state is always IDLE.

**Outputs and validity**
- `req_ready` is 0 in WORK and DONE. Requests arriving then wait; they are never dropped or latched.
- `out_nib` and `out_id` are registered and hold their last values in IDLE and DONE. They are meaningful only while `out_valid` is high.
- An illegal state encoding recovers to IDLE.

**Boundary conditions**
- All requesters valid at once: strict rotation 0, 1, 2, 3, 0, … starting from the reset pointer.
- `req_valid` or `req_data` changing after capture has no effect on the transaction in flight.
- `out_ready` held low indefinitely: the block stalls in WORK and no further grants occur.
- `out_ready` high before `out_valid`: harmless; the handshake completes on the first WORK cycle.
- `NUM_REQ` = 1: the pointer stays 0 and `out_id` is always 0.
- `rst_n` low at any point, including mid-WORK: the in-flight transaction is discarded and every output takes its reset value immediately.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, capture registers 0, `out_valid` 0, `out_nib` 0, `out_id` 0, `req_ready` 0, `busy` 0, `done_count` 0.
- Reset deassertion is synchronised internally. The first grant is possible on the second rising edge after `rst_n` rises.
- Grant-to-result latency: if `req_ready` is high in cycle T, `out_valid` rises in cycle T+1.
- Best-case throughput: one transaction every 3 cycles (IDLE, WORK, DONE), with `out_ready` tied high and requests always pending.
- `req_ready` has a combinational path from `req_valid`. `out_valid`, `out_nib`, `out_id`, `busy` and `done_count` are driven from registers only.

## Structure
- Package `fsm_pkg` holds:
  - `state_t` enum `{IDLE, WORK, DONE}`, typed `logic [1:0]`;
  - the `NIB_W = 4` constant;
  - a function computing `ID_W`.
- One sub-module, `fsm_rr_pick`: purely combinational.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `grant_any`, `grant_idx`, and a one-hot grant vector.
- The top level contains the state register, capture registers, pointer and counter.

## Test plan
1. Reset, then requester 2 valid with data 0xA5 → `req_ready` = 0b0100 for one cycle. Next cycle: `out_valid` = 1, `out_nib` = 0xA, `out_id` = 2. Two cycles after the handshake, `done_count` = 1.
2. All four requesters valid, data 0x1_, 0x2_, 0x3_, 0x4_ (upper nibbles 1, 2, 3, 4), `out_ready` = 1 → results come out with `out_id` 0, 1, 2, 3, 0 and `out_nib` 1, 2, 3, 4, 1. Spacing is exactly 3 cycles.
3. Requester 1 is granted, then `out_ready` is held low for 10 cycles → `out_valid` stays 1 with `out_nib` and `out_id` stable. No `req_ready` pulses occur. The block completes one cycle after `out_ready` rises.
4. Requester 0 is granted with data 0xF0, then its data changes to 0x00 during WORK → `out_nib` stays 0xF.
5. `rst_n` pulsed low mid-WORK → `out_valid`, `busy` and `done_count` are 0 immediately. The next grant starts at requester 0.
6. Preload `done_count` to 0xFFFF (force or 65535 transactions), then complete one more transaction → `done_count` = 0x0000.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the fsm_arb round-robin scheduler.
//   state_t    : transaction phase encoding (IDLE -> WORK -> DONE)
//   NIB_W      : width of the extracted result nibble
//   calc_id_w  : requester-ID width for a given requester count (minimum 1 bit)
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORK = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int calc_id_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_rr_pick.sv
// Combinational round-robin pick.
// Scans req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set
// bit wins.
//   req_valid  in   NUM_REQ  pending requests
//   rr_ptr     in   ID_W     highest-priority requester this cycle
//   grant_any  out  1        a winner exists
//   grant_idx  out  ID_W     index of the winner (0 when none)
//   grant_oh   out  NUM_REQ  one-hot winner (all zero when none)
module fsm_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_idx,
    output logic [NUM_REQ-1:0] grant_oh
);

    int idx;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_ptr is always < NUM_REQ, so a single subtraction wraps it.
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any     = 1'b1;
                grant_idx     = ID_W'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_arb.sv
// Round-robin scheduler sharing one nibble-extract engine among NUM_REQ
// requesters. Each transaction runs IDLE (grant + capture), WORK (present the
// upper nibble on a valid/ready port), DONE (advance pointer and counter).
//
// Handshakes: req_valid/req_ready per requester - a request is accepted on a
// rising edge where both are high; out_valid/out_ready - the result is
// consumed on a rising edge where both are high, and out_nib/out_id hold
// steady while out_valid is high and out_ready is low.
//
//   clk         in   1               rising-edge clock
//   rst_n       in   1               asynchronous active-low reset
//   req_valid   in   NUM_REQ         per-requester request valid
//   req_data    in   NUM_REQ*DATA_W  payload i at [i*DATA_W +: DATA_W]
//   req_ready   out  NUM_REQ         one-hot accept strobe (combinational)
//   out_valid   out  1               result valid
//   out_ready   in   1               result accepted
//   out_nib     out  4               upper nibble of the captured payload
//   out_id      out  ID_W            granted requester index
//   busy        out  1               state is not IDLE
//   done_count  out  16              completed transactions (wraps)
module fsm_arb
    import fsm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIB_W-1:0]            out_nib,
    output logic [ID_W-1:0]             out_id,
    output logic                        busy,
    output logic [15:0]                 done_count
);

    state_t              state;
    logic [DATA_W-1:0]   cap_data;
    logic [ID_W-1:0]     cap_id;
    logic [ID_W-1:0]     rr_ptr;
    logic [15:0]         done_cnt;
    logic                rst_q;

    logic                grant_any;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_oh;

    // Reset assertion is immediate; release is taken through one flop so the
    // FSM starts moving cleanly on the edge after rst_q sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    fsm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_any (grant_any),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh)
    );

    // Grants are only offered while idle and out of reset.
    assign req_ready = (rst_q && state == IDLE) ? grant_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_data <= '0;
            cap_id   <= '0;
            rr_ptr   <= '0;
            done_cnt <= '0;
        end else if (rst_q) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                        cap_id   <= grant_idx;
                        state    <= WORK;
                    end
                end
                WORK: begin
                    if (out_ready) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Next search starts just after the requester served.
                    if (cap_id == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= cap_id + ID_W'(1);
                    end
                    done_cnt <= done_cnt + 16'd1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = (state == WORK);
    assign busy       = (state != IDLE);
    assign out_nib    = cap_data[DATA_W-1 -: NIB_W];
    assign out_id     = cap_id;
    assign done_count = done_cnt;

endmodule

// File: tb/tb_fsm_arb.sv
// Self-checking bench for fsm_arb (NUM_REQ=4, DATA_W=8).
// A cycle-level reference model built from the transaction rules predicts
// grants, out_valid, busy and done_count; predicted results go into exp_q and
// a separate monitor compares them whenever out_valid is high.
module tb_fsm_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [3:0]                out_nib;
    logic [ID_W-1:0]           out_id;
    logic                      busy;
    logic [15:0]               done_count;

    logic [DATA_W-1:0]         data_arr [NUM_REQ];

    int n_checks;
    int n_fail;

    // expected result: {id, nibble}
    logic [ID_W+3:0] exp_q[$];

    // reference model state
    int          m_stage;   // 0 waiting for a grant, 1 result offered, 2 housekeeping
    int          m_ptr;
    int          m_cur;
    int          m_win;
    int          m_j;
    logic        m_armed;
    logic [15:0] m_cnt;
    logic [NUM_REQ-1:0] m_exp_ready;
    int          pre_seq;
    int          m_pre_seen;

    logic [ID_W+3:0] mon_item;

    fsm_arb #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nib    (out_nib),
        .out_id     (out_id),
        .busy       (busy),
        .done_count (done_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = data_arr[i];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(negedge clk) begin : model
        if (!rst_n) begin
            m_stage    = 0;
            m_ptr      = 0;
            m_cur      = 0;
            m_armed    = 1'b0;
            m_cnt      = 16'h0;
            m_pre_seen = pre_seq;
            exp_q.delete();
        end else begin
            if (pre_seq != m_pre_seen) begin
                m_cnt      = 16'hFFFF;
                m_pre_seen = pre_seq;
            end
            m_win = -1;
            if (m_armed && m_stage == 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    m_j = (m_ptr + k) % NUM_REQ;
                    if (m_win < 0 && req_valid[m_j]) m_win = m_j;
                end
            end
            m_exp_ready = (m_win >= 0) ? NUM_REQ'(1 << m_win) : '0;
            check("req_ready",  32'(req_ready),  32'(m_exp_ready));
            check("out_valid",  32'(out_valid),  32'(m_stage == 1));
            check("busy",       32'(busy),       32'(m_stage != 0));
            check("done_count", 32'(done_count), 32'(m_cnt));
            case (m_stage)
                0: if (m_win >= 0) begin
                    exp_q.push_back({ID_W'(m_win), data_arr[m_win][DATA_W-1 -: 4]});
                    m_cur   = m_win;
                    m_stage = 1;
                end
                1: if (out_ready) m_stage = 2;
                default: begin
                    m_ptr   = (m_cur + 1) % NUM_REQ;
                    m_cnt   = m_cnt + 16'd1;
                    m_stage = 0;
                end
            endcase
            m_armed = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got id %0d nib %0h expected no result", out_id, out_nib);
            end else begin
                mon_item = exp_q[0];
                check("out_id",  32'(out_id),  32'(mon_item[ID_W+3:4]));
                check("out_nib", 32'(out_nib), 32'(mon_item[3:0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_done_count", 32'(done_count), 32'h0);
        check("rst_req_ready",  32'(req_ready),  32'h0);
        check("rst_out_nib",    32'(out_nib),    32'h0);
        check("rst_out_id",     32'(out_id),     32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int t;
        req_valid = '0;
        t = 0;
        while (m_stage != 0 && t < 20) begin
            step(1);
            t++;
        end
        n_checks++;
        if (m_stage != 0) begin
            n_fail++;
            $display("FAIL wait_idle: model stage %0d still busy after %0d cycles", m_stage, t);
        end
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pre_seq   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) data_arr[i] = '0;
        step(3);
        check_reset_outputs();
        rst_n = 1'b1;

        // single request from requester 2
        data_arr[2] = 8'hA5;
        req_valid   = 4'b0100;
        out_ready   = 1'b1;
        step(2);
        req_valid = '0;
        step(4);
        check("t1_done_count", 32'(done_count), 32'h1);

        // all requesters, strict rotation from the reset pointer
        do_reset();
        data_arr[0] = 8'h1C; data_arr[1] = 8'h2D; data_arr[2] = 8'h3E; data_arr[3] = 8'h4F;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        step(16);
        wait_idle();

        // long stall in WORK, other requests pile up meanwhile
        data_arr[1] = 8'h7C;
        req_valid   = 4'b0010;
        out_ready   = 1'b0;
        step(2);
        req_valid = 4'b1111;
        step(10);
        out_ready = 1'b1;
        step(1);
        req_valid = '0;
        wait_idle();

        // payload change after capture
        data_arr[0] = 8'hF0;
        req_valid   = 4'b0001;
        out_ready   = 1'b0;
        step(2);
        req_valid   = '0;
        data_arr[0] = 8'h00;
        step(3);
        out_ready = 1'b1;
        wait_idle();

        // reset mid-WORK, then restart from requester 0
        req_valid = 4'b1111;
        out_ready = 1'b0;
        step(4);
        do_reset();
        out_ready = 1'b1;
        step(6);
        wait_idle();

        // counter wrap
        force dut.done_cnt = 16'hFFFF;
        pre_seq++;
        #1;
        release dut.done_cnt;
        step(1);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step(2);
        req_valid = '0;
        wait_idle();
        check("wrap_done_count", 32'(done_count), 32'h0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            for (int i = 0; i < NUM_REQ; i++) data_arr[i] = DATA_W'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        out_ready = 1'b1;
        wait_idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
